keyboard_button_mapper: RTL

Converts the raw scan-code byte stream from the keyboard receiver into per-player controller button state, using a runtime-programmable key map.
- Handles make, break (F0) and extended (E0) prefixes.
- Holds a live pressed-button bitmask for each player.
- Queues press/release events in a small FIFO for the controller-emulation mux.
- Successor to the fixed single-table decoder: more players, a remappable map, break handling, event buffering.

---
 rtl/keyboard_button_mapper_if.sv | 29 ++
 rtl/keyboard_button_mapper.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keyboard_button_mapper_if.sv
// Signal bundle between the scan-code source, the key-map programmer and the event consumer.
interface keyboard_button_mapper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int MAP_ENTRIES = 16,
    parameter int FIFO_DEPTH  = 8
);
    logic                           code_valid;
    logic [7:0]                     code_data;
    logic                           map_we;
    logic [$clog2(MAP_ENTRIES)-1:0] map_idx;
    logic [15:0]                    map_wdata;
    logic                           clear;
    logic [NUM_PLAYERS*12-1:0]      btn_state;
    logic                           evt_valid;
    logic                           evt_ready;
    logic [7:0]                     evt_data;
    logic [$clog2(FIFO_DEPTH):0]    evt_count;
    logic                           overflow;

    modport master (
        output code_valid, code_data, map_we, map_idx, map_wdata, clear, evt_ready,
        input  btn_state, evt_valid, evt_data, evt_count, overflow
    );

    modport slave (
        input  code_valid, code_data, map_we, map_idx, map_wdata, clear, evt_ready,
        output btn_state, evt_valid, evt_data, evt_count, overflow
    );
endinterface

// File: rtl/keyboard_button_mapper.sv
// Scan-code parser plus programmable key map driving per-player button state and a press/release
// event FIFO.
module keyboard_button_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int MAP_ENTRIES = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    keyboard_button_mapper_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BTN_W = NUM_PLAYERS * 12;

    // Bit 0 = extended prefix seen, bit 1 = break prefix seen.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_ext_q, s1_ext_d;
    logic             s1_make_q, s1_make_d;
    logic [7:0]       s1_scan_q, s1_scan_d;
    logic [15:0]      map_q [MAP_ENTRIES];
    logic [15:0]      map_d [MAP_ENTRIES];
    logic [BTN_W-1:0] btn_q, btn_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       last_q, last_d;

    logic             hit;
    logic [1:0]       hit_player;
    logic [3:0]       hit_button;
    logic [BTN_W-1:0] hit_mask;
    logic             changed;
    logic [7:0]       evt_word;
    logic             pop, full, accept, drop;

    always_comb begin
        state_d    = state_q;
        s1_valid_d = 1'b0;
        s1_ext_d   = s1_ext_q;
        s1_make_d  = s1_make_q;
        s1_scan_d  = s1_scan_q;
        if (bus.code_valid) begin
            if (bus.code_data == 8'hE0) begin
                state_d = state_q | ST_EXT;
            end else if (bus.code_data == 8'hF0) begin
                state_d = state_q | ST_BRK;
            end else begin
                s1_valid_d = 1'b1;
                s1_ext_d   = state_q[0];
                s1_make_d  = ~state_q[1];
                s1_scan_d  = bus.code_data;
                state_d    = ST_IDLE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MAP_ENTRIES; i++) begin
            map_d[i] = map_q[i];
        end
        if (bus.map_we) begin
            map_d[bus.map_idx] = bus.map_wdata;
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit        = 1'b0;
        hit_player = 2'd0;
        hit_button = 4'd0;
        for (int i = MAP_ENTRIES - 1; i >= 0; i--) begin
            if (map_q[i][15] && map_q[i][14] == s1_ext_q && map_q[i][13:6] == s1_scan_q &&
                map_q[i][3:0] != 4'd0 && map_q[i][3:0] <= 4'd12 &&
                32'(map_q[i][5:4]) < NUM_PLAYERS) begin
                hit        = 1'b1;
                hit_player = map_q[i][5:4];
                hit_button = map_q[i][3:0];
            end
        end
        hit_mask = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int b = 1; b <= 12; b++) begin
                if (hit_player == 2'(p) && hit_button == 4'(b)) begin
                    hit_mask[p*12 + b - 1] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        changed  = s1_valid_q && hit &&
                   (s1_make_q ? ((btn_q & hit_mask) == '0) : ((btn_q & hit_mask) != '0));
        evt_word = {s1_make_q, hit_player, 1'b0, hit_button};
        btn_d    = btn_q;
        if (changed) begin
            btn_d = s1_make_q ? (btn_q | hit_mask) : (btn_q & ~hit_mask);
        end
    end

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    always_comb begin
        pop        = (count_q != '0) && bus.evt_ready;
        full       = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        accept     = changed && (!full || pop);
        drop       = changed && full && !pop;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        last_d     = last_q;
        overflow_d = overflow_q | drop;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (accept) begin
            mem_d[wr_ptr_q] = evt_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_ext_q   <= 1'b0;
            s1_make_q  <= 1'b0;
            s1_scan_q  <= 8'd0;
            btn_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_ext_q   <= s1_ext_d;
            s1_make_q  <= s1_make_d;
            s1_scan_q  <= s1_scan_d;
            btn_q      <= btn_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    // The key map survives a soft clear; only a hard reset disables it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAP_ENTRIES; i++) begin
                map_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < MAP_ENTRIES; i++) begin
                map_q[i] <= map_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign bus.btn_state = btn_q;
    assign bus.evt_valid = (count_q != '0);
    assign bus.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign bus.evt_count = count_q;
    assign bus.overflow  = overflow_q;
endmodule
